chimera_clu_gate_ctrl: RTL and testbench
========================================

# chimera_clu_gate_ctrl

Safe clock-gate sequencer for the cluster domain. It takes per-cluster gate requests from the top-level config registers and drains each cluster's AXI traffic behind an isolation barrier before gating its clock. It ungates with a settle delay before releasing isolation. A single shared sequencer serves one cluster at a time, with round-robin selection, which limits clock-enable inrush. It sits in the SoC clock domain, between the register file and the per-cluster `tc_clk_gating` cells and AXI isolation stages.

## Interface
- `NumClusters`, default 5: number of gated clusters.
- `SettleCycles`, default 4: cycles between clock enable and isolation release (≥1).
- `TimeoutCycles`, default 1024: maximum ISOLATE cycles with `busy_i` high before the gate attempt is aborted (≥1).
- `soc_clk_i`, in, 1: SoC clock; the only clock.
- `rst_ni`, in, 1: reset, synchronous, active-low.
- `gate_req_i`, in, NumClusters: 1 = cluster clock should be gated (level, from reg2hw).
- `busy_i`, in, NumClusters: cluster has outstanding narrow/wide AXI transactions.
- `err_clr_i`, in, NumClusters: single-cycle pulse that clears the matching `err_o` bit and its block bit.
- `isolate_o`, out, NumClusters: blocks new AXI requests into and out of the cluster.
- `clk_en_o`, out, NumClusters: drives `en_i` of the cluster clock gate.
- `gated_o`, out, NumClusters: status, 1 = clock gated and isolated.
- `err_o`, out, NumClusters: sticky drain-timeout flag.
- `seq_busy_o`, in/out direction out, 1: sequencer is not in IDLE.

## Operation
- Per-cluster registered `gated` bit. Every output is a register.
- `pending[i] = (gate_req_i[i] != gated[i]) & ~blocked[i]`.
- FSM states: IDLE, ISOLATE, WAKE. Register `cur` holds the index of the cluster being served.
- **IDLE**
  - If `pending` is nonzero, the round-robin arbiter picks `cur`, starting from last served + 1.
  - If `gated[cur]=0`: go to ISOLATE, set `isolate_o[cur]=1`, counter=0.
  - If `gated[cur]=1`: go to WAKE, set `clk_en_o[cur]=1`, counter=0.
- **ISOLATE**
  - `busy_i[cur]` low and `gate_req_i[cur]` high: set `clk_en_o[cur]=0` and `gated[cur]=1`, go to IDLE. `isolate_o` stays 1.
  - `gate_req_i[cur]` low (request withdrawn): set `isolate_o[cur]=0`, go to IDLE, no error. The withdrawal check takes priority over the drain check.
  - Otherwise the counter increments. When the counter reaches `TimeoutCycles-1` with busy still high: set `isolate_o[cur]=0`, `err_o[cur]=1`, `blocked[cur]=1`, go to IDLE.
- **WAKE**
  - The counter increments each cycle. When it reaches `SettleCycles-1`: set `isolate_o[cur]=0`, `gated[cur]=0`, go to IDLE.
  - `gate_req_i` changes during WAKE are ignored until IDLE, where they are re-evaluated as a new pending request.
- `blocked[i]` clears when `gate_req_i[i]` is low or `err_clr_i[i]` pulses. `err_o[i]` clears only on `err_clr_i[i]`. If the clear and a new timeout for the same `i` happen in the same cycle, the set wins.
- `clk_en_o[i] = 0` only while `gated[i]=1`. `isolate_o[i]` is always 1 whenever `clk_en_o[i]=0`.
- `seq_busy_o` = (state != IDLE).

## Timing
- Reset values: state IDLE; `clk_en_o` all 1; `isolate_o`, `gated_o`, `err_o` and `seq_busy_o` all 0; round-robin pointer 0; blocked all 0.
- Gate latency: `gate_req_i` high in cycle 0 with the sequencer idle and `busy_i` low.
  - `isolate_o` high at cycle 1.
  - `clk_en_o` low and `gated_o` high at cycle 2.
- Wake latency: `gate_req_i` low in cycle 0.
  - `clk_en_o` high at cycle 1.
  - `isolate_o` and `gated_o` low at cycle 1+SettleCycles.
- Back-to-back service: one IDLE cycle separates consecutive clusters.
- Counter width: `$clog2(max(SettleCycles,TimeoutCycles)+1)`. The counter saturates and never wraps.
- Reset mid-sequence: all outputs return to their reset values in the next cycle, so clocks are ungated and isolation is released.

## Structure
- A shared package `chimera_clu_gate_pkg` holds the FSM state enum and a default-parameter localparam.
- One sub-module, `rr_arb_tree` from common_cells, does the pending selection with `ExtPrio=0` and `LockIn=0`. Its request input is valid only while the FSM is in IDLE.
- The counter, FSM, and per-cluster `gated`/`blocked`/`err` registers are inline.

## Test plan
- **Single gate/ungate.** Cluster 2 has busy=0; set `gate_req_i=5'b00100`.
  - `isolate_o[2]`=1 at +1; `clk_en_o[2]`=0 and `gated_o[2]`=1 at +2.
  - Clear the request: `clk_en_o[2]`=1 at +1; isolate and gated drop at +5 (SettleCycles=4).
- **Drain wait.** `busy_i[0]`=1 for 10 cycles after isolation.
  - `clk_en_o[0]` stays 1 during those cycles and falls the cycle after busy drops.
  - No error is raised.
- **Timeout.** TimeoutCycles=16, `busy_i[1]` held high.
  - `err_o[1]`=1 and `isolate_o[1]`=0 after 16 ISOLATE cycles.
  - Cluster 1 is not re-attempted while the request stays high.
  - An `err_clr_i[1]` pulse triggers a new attempt.
- **Arbitration.** Set `gate_req_i=5'b11111` in one cycle with all busy=0.
  - Clusters are gated in order 0,1,2,3,4, one every 2 cycles, with never more than one isolate edge in flight.
  - The following ungate sequence resumes from pointer 0.
- **Withdraw and reset.**
  - Request withdrawn during ISOLATE: isolate drops next cycle with no error.
  - `rst_ni`=0 asserted in WAKE: next cycle all `clk_en_o`=1, all `isolate_o`=0, all `gated_o`=0.

Source files
------------

// File: rtl/chimera_clu_gate_pkg.sv
// chimera_clu_gate_pkg: shared types and defaults for the cluster clock-gate sequencer.
package chimera_clu_gate_pkg;
  typedef enum logic [1:0] {IDLE, ISOLATE, WAKE} state_e;
  localparam int unsigned DefaultNumClusters = 5;
endpackage

// File: rtl/rr_arb_tree.sv
// rr_arb_tree: round-robin arbiter; priority starts one past the last granted index.
module rr_arb_tree #(
  parameter int unsigned NumIn = 2,
  parameter bit ExtPrio = 1'b0,
  parameter bit LockIn = 1'b0,
  localparam int unsigned IdxWidth = (NumIn > 1) ? $clog2(NumIn) : 1
)(
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [IdxWidth-1:0] rr_i,
  input  logic [NumIn-1:0]    req_i,
  input  logic                gnt_i,
  output logic                req_o,
  output logic [IdxWidth-1:0] idx_o
);
  logic [IdxWidth-1:0] rr_q, ptr, pick, idx_q;
  logic lock_q;
  always_comb begin
    ptr = ExtPrio ? rr_i : rr_q;
    pick = '0;
    for (int k = NumIn - 1; k >= 0; k--)
      if (req_i[IdxWidth'((int'(ptr) + k) % NumIn)]) pick = IdxWidth'((int'(ptr) + k) % NumIn);
  end
  assign req_o = |req_i;
  // a stalled request keeps its decision when locking is enabled
  assign idx_o = (LockIn && lock_q) ? idx_q : pick;
  always_ff @(posedge clk_i)
    if (!rst_ni) begin
      rr_q <= '0;
      idx_q <= '0;
      lock_q <= 1'b0;
    end else begin
      idx_q <= idx_o;
      lock_q <= LockIn && req_o && !gnt_i;
      if (req_o && gnt_i) rr_q <= (idx_o == IdxWidth'(NumIn - 1)) ? '0 : idx_o + 1'b1;
    end
endmodule

// File: rtl/chimera_clu_gate_ctrl.sv
// chimera_clu_gate_ctrl: drains, isolates and gates cluster clocks one cluster at a time;
// ungates with a settle delay before releasing isolation.
module chimera_clu_gate_ctrl import chimera_clu_gate_pkg::*; #(
  parameter int unsigned NumClusters = DefaultNumClusters,
  parameter int unsigned SettleCycles = 4,
  parameter int unsigned TimeoutCycles = 1024
)(
  input  logic                   soc_clk_i,
  input  logic                   rst_ni,
  input  logic [NumClusters-1:0] gate_req_i,
  input  logic [NumClusters-1:0] busy_i,
  input  logic [NumClusters-1:0] err_clr_i,
  output logic [NumClusters-1:0] isolate_o,
  output logic [NumClusters-1:0] clk_en_o,
  output logic [NumClusters-1:0] gated_o,
  output logic [NumClusters-1:0] err_o,
  output logic                   seq_busy_o
);
  localparam int unsigned IdxW = (NumClusters > 1) ? $clog2(NumClusters) : 1;
  localparam int unsigned CntMax = (SettleCycles > TimeoutCycles) ? SettleCycles : TimeoutCycles;
  localparam int unsigned CntW = $clog2(CntMax + 1);
  state_e state_q;
  logic [IdxW-1:0] cur_q, sel;
  logic [CntW-1:0] cnt_q, cnt_inc;
  logic [NumClusters-1:0] blocked_q, pending, arb_req;
  logic sel_valid;
  assign pending = (gate_req_i ^ gated_o) & ~blocked_q;
  assign arb_req = (state_q == IDLE) ? pending : '0;
  assign cnt_inc = (cnt_q == CntW'(CntMax)) ? cnt_q : cnt_q + 1'b1;
  rr_arb_tree #(
    .NumIn(NumClusters),
    .ExtPrio(1'b0),
    .LockIn(1'b0)
  ) i_arb (
    .clk_i(soc_clk_i),
    .rst_ni(rst_ni),
    .rr_i('0),
    .req_i(arb_req),
    .gnt_i(state_q == IDLE),
    .req_o(sel_valid),
    .idx_o(sel)
  );
  always_ff @(posedge soc_clk_i)
    if (!rst_ni) begin
      state_q <= IDLE;
      cur_q <= '0;
      cnt_q <= '0;
      isolate_o <= '0;
      clk_en_o <= '1;
      gated_o <= '0;
      err_o <= '0;
      blocked_q <= '0;
      seq_busy_o <= 1'b0;
    end else begin
      // per-bit clears first so a same-cycle timeout below overrides them
      blocked_q <= blocked_q & gate_req_i & ~err_clr_i;
      err_o <= err_o & ~err_clr_i;
      case (state_q)
        IDLE: if (sel_valid) begin
          cur_q <= sel;
          cnt_q <= '0;
          seq_busy_o <= 1'b1;
          if (gated_o[sel]) begin
            state_q <= WAKE;
            clk_en_o[sel] <= 1'b1;
          end else begin
            state_q <= ISOLATE;
            isolate_o[sel] <= 1'b1;
          end
        end
        ISOLATE: if (!gate_req_i[cur_q]) begin
          isolate_o[cur_q] <= 1'b0;
          state_q <= IDLE;
          seq_busy_o <= 1'b0;
        end else if (!busy_i[cur_q]) begin
          clk_en_o[cur_q] <= 1'b0;
          gated_o[cur_q] <= 1'b1;
          state_q <= IDLE;
          seq_busy_o <= 1'b0;
        end else if (cnt_q == CntW'(TimeoutCycles - 1)) begin
          isolate_o[cur_q] <= 1'b0;
          err_o[cur_q] <= 1'b1;
          blocked_q[cur_q] <= 1'b1;
          state_q <= IDLE;
          seq_busy_o <= 1'b0;
        end else cnt_q <= cnt_inc;
        WAKE: if (cnt_q == CntW'(SettleCycles - 1)) begin
          isolate_o[cur_q] <= 1'b0;
          gated_o[cur_q] <= 1'b0;
          state_q <= IDLE;
          seq_busy_o <= 1'b0;
        end else cnt_q <= cnt_inc;
        default: begin
          state_q <= IDLE;
          seq_busy_o <= 1'b0;
        end
      endcase
    end
endmodule

// File: tb/tb_chimera_clu_gate_ctrl.sv
// tb_chimera_clu_gate_ctrl: job-level reference model feeds a per-cycle expectation queue;
// a monitor pops and compares every output after each clock edge.
module tb_chimera_clu_gate_ctrl;
  localparam int N = 5, S = 4, T = 16;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [N-1:0] gate_req = '0, busy = '0, err_clr = '0;
  logic [N-1:0] isolate, clk_en, gated, err;
  logic seq_busy;
  int compared = 0, mismatched = 0;
  always #5 clk = ~clk;
  chimera_clu_gate_ctrl #(.NumClusters(N), .SettleCycles(S), .TimeoutCycles(T)) dut (
    .soc_clk_i(clk),
    .rst_ni(rst_n),
    .gate_req_i(gate_req),
    .busy_i(busy),
    .err_clr_i(err_clr),
    .isolate_o(isolate),
    .clk_en_o(clk_en),
    .gated_o(gated),
    .err_o(err),
    .seq_busy_o(seq_busy)
  );
  typedef struct packed {logic [N-1:0] iso, en, gat, er; logic sb;} out_t;
  out_t exp_q[$];
  // model: cluster status arrays plus one in-flight job with its start edge
  logic [N-1:0] m_iso, m_en, m_gated, m_err, m_blocked;
  int m_ptr, m_cl, m_start, m_edge = 0;
  bit m_active, m_wake;
  task automatic model_step();
    logic [N-1:0] pend, nb, ne;
    if (!rst_n) begin
      m_iso = '0; m_en = '1; m_gated = '0; m_err = '0; m_blocked = '0;
      m_ptr = 0; m_active = 0;
    end else begin
      nb = m_blocked & gate_req & ~err_clr;
      ne = m_err & ~err_clr;
      if (!m_active) begin
        pend = (gate_req ^ m_gated) & ~m_blocked;
        for (int k = N - 1; k >= 0; k--)
          if (pend[(m_ptr + k) % N]) begin m_cl = (m_ptr + k) % N; m_active = 1; end
        if (m_active) begin
          m_ptr = (m_cl + 1) % N;
          m_start = m_edge;
          m_wake = m_gated[m_cl];
          if (m_wake) m_en[m_cl] = 1'b1; else m_iso[m_cl] = 1'b1;
        end
      end else if (m_wake) begin
        if (m_edge - m_start >= S) begin m_iso[m_cl] = 0; m_gated[m_cl] = 0; m_active = 0; end
      end else if (!gate_req[m_cl]) begin
        m_iso[m_cl] = 0; m_active = 0;
      end else if (!busy[m_cl]) begin
        m_en[m_cl] = 0; m_gated[m_cl] = 1; m_active = 0;
      end else if (m_edge - m_start >= T) begin
        m_iso[m_cl] = 0; ne[m_cl] = 1; nb[m_cl] = 1; m_active = 0;
      end
      m_blocked = nb;
      m_err = ne;
    end
    m_edge++;
    exp_q.push_back(out_t'({m_iso, m_en, m_gated, m_err, m_active}));
  endtask
  task automatic tick(int n);
    repeat (n) begin
      model_step();
      @(negedge clk);
    end
  endtask
  task automatic check(string name, logic [N-1:0] got, logic [N-1:0] want);
    compared++;
    if (got !== want) begin
      mismatched++;
      $display("FAIL %s at %0t: got %b want %b", name, $time, got, want);
    end
  endtask
  initial begin
    out_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("isolate", isolate, e.iso);
        check("clk_en", clk_en, e.en);
        check("gated", gated, e.gat);
        check("err", err, e.er);
        check("seq_busy", {{(N-1){1'b0}}, seq_busy}, {{(N-1){1'b0}}, e.sb});
      end
    end
  end
  initial begin
    @(negedge clk);
    rst_n = 0; tick(2); rst_n = 1; tick(2);
    gate_req = 5'b00100; tick(4); gate_req = '0; tick(8);
    busy = 5'b00001; gate_req = 5'b00001; tick(10); busy = '0; tick(3); gate_req = '0; tick(8);
    busy = 5'b00010; gate_req = 5'b00010; tick(30);
    err_clr = 5'b00010; tick(1); err_clr = '0; tick(4);
    busy = '0; tick(3); gate_req = '0; tick(8);
    gate_req = 5'b11111; tick(14); gate_req = '0; tick(35);
    busy = 5'b01000; gate_req = 5'b01000; tick(3); gate_req = '0; tick(3); busy = '0;
    gate_req = 5'b00100; tick(4); gate_req = '0; tick(2); rst_n = 0; tick(1); rst_n = 1; tick(4);
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) if ($urandom_range(99) < 4) gate_req[i] = ~gate_req[i];
      busy = (c % 200 < 40) ? '1 : N'($urandom & $urandom);
      err_clr = ($urandom_range(99) < 5) ? N'($urandom) : '0;
      rst_n = ($urandom_range(999) != 0);
      tick(1);
    end
    rst_n = 1; err_clr = '0; busy = '0; gate_req = '0; tick(40);
    compared++;
    if (exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL drain: got %0d pending expectations want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
